// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame FSM states and baud divisor helper.
// Intended to be reused unchanged by the matching receiver.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; occupancy is the pointer difference.
// Storage is not reset, only the pointers are.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Same low bits with differing wrap bits means the writer has lapped the reader.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign count    = CW'(wr_ptr_q - rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input into a FIFO, LSB-first serialiser with
// runtime parity and stop-bit selection latched per frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_BITS-1:0]       s_data,
  input  logic [1:0]                 parity_mode,
  input  logic                       two_stop,
  output logic                       tx_serial,
  output logic                       tx_active,
  output logic                       tx_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW  = $clog2(CPB);
  localparam int NW  = $clog2(DATA_BITS);

  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign s_ready = !fifo_full;

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [NW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [1:0]           mode_q, mode_d;
  logic                 two_q, two_d;
  logic                 tx_q, tx_d;
  logic                 act_q, act_d;
  logic                 done_q, done_d;
  logic                 bit_end, has_par;

  assign bit_end = (baud_q == BW'(CPB - 1));
  assign has_par = (mode_q == PARITY_EVEN) || (mode_q == PARITY_ODD);

  // Every transition sets tx_d to the level of the bit being entered, so the line
  // is a flop and changes exactly on bit boundaries.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    mode_d   = mode_q;
    two_d    = two_q;
    tx_d     = tx_q;
    act_d    = act_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        act_d = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          par_d    = 1'b0;
          mode_d   = parity_mode;
          two_d    = two_stop;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = START;
          tx_d     = 1'b0;
          act_d    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          par_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == NW'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (has_par) begin
              state_d = PARITY;
              tx_d    = (mode_q == PARITY_ODD) ? ~par_q : par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + NW'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
            par_d   = par_q ^ shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // bit_q counts stop periods already sent.
        if (bit_end) begin
          if (two_q && (bit_q == '0)) begin
            bit_d = NW'(1);
          end else begin
            state_d = IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
            act_d   = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        act_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      mode_q  <= PARITY_NONE;
      two_q   <= 1'b0;
      tx_q    <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      mode_q  <= mode_d;
      two_q   <= two_d;
      tx_q    <= tx_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign tx_serial = tx_q;
  assign tx_active = act_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level line model checked every cycle on the 8-bit
// instance, plus hand-computed frame expectations on both 8-bit and 5-bit instances.
module tb_uart_tx_fifo;

  logic clk, rst;
  int   n_chk = 0;
  int   n_pass = 0;

  // 8-bit, depth-4 instance
  logic       a_valid, a_ready, a_two, a_tx, a_act, a_done;
  logic [7:0] a_data;
  logic [1:0] a_mode;
  logic [2:0] a_cnt;

  // 5-bit, depth-4 instance
  logic       b_valid, b_ready, b_two, b_tx, b_act, b_done;
  logic [4:0] b_data;
  logic [1:0] b_mode;
  logic [2:0] b_cnt;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .parity_mode(a_mode), .two_stop(a_two), .tx_serial(a_tx), .tx_active(a_act),
    .tx_done(a_done), .fifo_count(a_cnt)
  );

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(5), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .parity_mode(b_mode), .two_stop(b_two), .tx_serial(b_tx), .tx_active(b_act),
    .tx_done(b_done), .fifo_count(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Line model for instance A: words queue up, and each frame is expanded into its
  // per-cycle line levels when it leaves the buffer.
  logic [7:0] mq[$];
  logic       fq[$];
  logic       m_tx = 1'b1, m_act = 1'b0, m_done = 1'b0;
  int         m_cnt = 0;
  bit         m_push, m_pop;

  task automatic build_frame(input logic [7:0] d, input logic [1:0] md, input logic two);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (md == 2'b01) lv.push_back(^d);
    else if (md == 2'b10) lv.push_back(~^d);
    lv.push_back(1'b1);
    if (two) lv.push_back(1'b1);
    foreach (lv[k]) repeat (10) fq.push_back(lv[k]);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete(); fq.delete();
      m_tx = 1'b1; m_act = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      m_push = a_valid && (m_cnt != 4);
      m_pop  = 1'b0;
      m_done = 1'b0;
      if (fq.size() != 0) begin
        m_tx = fq.pop_front();
      end else if (m_act) begin
        m_act = 1'b0; m_tx = 1'b1; m_done = 1'b1;
      end else if (mq.size() != 0) begin
        build_frame(mq.pop_front(), a_mode, a_two);
        m_tx = fq.pop_front(); m_act = 1'b1; m_pop = 1'b1;
      end
      if (m_push) mq.push_back(a_data);
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx_serial", 32'(a_tx), 32'(m_tx));
    chk("tx_active", 32'(a_act), 32'(m_act));
    chk("tx_done", 32'(a_done), 32'(m_done));
    chk("s_ready", 32'(a_ready), 32'(m_cnt != 4));
    chk("fifo_count", 32'(a_cnt), 32'(m_cnt));
  end

  int a_done_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (a_done) a_done_cnt++;
  end

  task automatic push(input bit use_b, input logic [7:0] d, input bit hold);
    bit rdy, ok;
    ok = 1'b0;
    if (use_b) begin b_valid = 1'b1; b_data = d[4:0]; end
    else begin a_valid = 1'b1; a_data = d; end
    for (int i = 0; i < 400 && !ok; i++) begin
      rdy = use_b ? b_ready : a_ready;
      @(posedge clk); #2;
      if (rdy) ok = 1'b1;
    end
    chk("push_accepted", 32'(ok), 32'd1);
    if (!hold) begin
      if (use_b) b_valid = 1'b0; else a_valid = 1'b0;
    end
  endtask

  // Waits for a frame, returns its active length, mid-bit line levels and the
  // tx_done level on the first cycle after tx_active falls.
  task automatic measure(input bit use_b, output int len, output logic [11:0] lv, output logic dn);
    int w;
    len = 0; lv = '0; w = 0;
    @(negedge clk);
    while (!(use_b ? b_act : a_act) && w < 50) begin @(negedge clk); w++; end
    while ((use_b ? b_act : a_act) && len < 300) begin
      if ((len % 10) == 5 && (len / 10) < 12) lv[len/10] = use_b ? b_tx : a_tx;
      len++;
      @(negedge clk);
    end
    dn = use_b ? b_done : a_done;
  endtask

  task automatic wait_idle_a();
    int w;
    w = 0;
    while ((a_cnt != 0 || a_act || a_done) && w < 2000) begin @(negedge clk); w++; end
    chk("idle_timeout", 32'(w < 2000), 32'd1);
  endtask

  int         len, lowc;
  logic [11:0] lv;
  logic       dn;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_mode = 2'b00; a_two = 1'b0;
    b_valid = 1'b0; b_data = '0; b_mode = 2'b00; b_two = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx", 32'(a_tx), 32'd1);
    chk("rst_active", 32'(a_act), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_count", 32'(a_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // 1: 0x41, 8N1
    push(1'b0, 8'h41, 1'b0);
    chk("t1_count_after_push", 32'(a_cnt), 32'd1);
    chk("t1_idle_after_push", 32'(a_act), 32'd0);
    measure(1'b0, len, lv, dn);
    chk("t1_len", 32'(len), 32'd100);
    chk("t1_bits", 32'(lv), 32'h282);
    chk("t1_done", 32'(dn), 32'd1);

    // 2: parity variants
    a_mode = 2'b01;
    push(1'b0, 8'h41, 1'b0);
    measure(1'b0, len, lv, dn);
    chk("t2_even_len", 32'(len), 32'd110);
    chk("t2_even_bits", 32'(lv), 32'h482);
    a_mode = 2'b10;
    push(1'b0, 8'h41, 1'b0);
    measure(1'b0, len, lv, dn);
    chk("t2_odd_len", 32'(len), 32'd110);
    chk("t2_odd_bits", 32'(lv), 32'h682);
    a_mode = 2'b11;
    push(1'b0, 8'h41, 1'b0);
    measure(1'b0, len, lv, dn);
    chk("t2_rsvd_len", 32'(len), 32'd100);
    chk("t2_rsvd_bits", 32'(lv), 32'h282);

    // 3: two stop bits, controls toggled mid-frame
    a_mode = 2'b00; a_two = 1'b1;
    push(1'b0, 8'hFF, 1'b0);
    fork
      measure(1'b0, len, lv, dn);
      begin repeat (30) @(posedge clk); #2; a_two = 1'b0; a_mode = 2'b10; end
    join
    chk("t3_len", 32'(len), 32'd110);
    chk("t3_bits", 32'(lv), 32'h7FE);
    chk("t3_done", 32'(dn), 32'd1);
    a_mode = 2'b00; a_two = 1'b0;
    wait_idle_a();

    // 4: back-pressure with s_valid held
    a_done_cnt = 0;
    for (int i = 1; i <= 4; i++) push(1'b0, 8'(i), 1'b1);
    chk("t4_ready_at_4", 32'(a_ready), 32'd1);
    push(1'b0, 8'h05, 1'b1);
    chk("t4_ready_full", 32'(a_ready), 32'd0);
    chk("t4_count_full", 32'(a_cnt), 32'd4);
    push(1'b0, 8'h06, 1'b0);
    wait_idle_a();
    repeat (3) @(negedge clk);
    chk("t4_done_pulses", 32'(a_done_cnt), 32'd6);

    // 5: 5-bit instance
    push(1'b1, 8'h15, 1'b0);
    measure(1'b1, len, lv, dn);
    chk("t5_len", 32'(len), 32'd70);
    chk("t5_bits", 32'(lv), 32'h06A);
    chk("t5_done", 32'(dn), 32'd1);

    // 6: reset during data bit 3 with two words queued
    push(1'b0, 8'h11, 1'b1);
    push(1'b0, 8'h22, 1'b1);
    push(1'b0, 8'h33, 1'b0);
    chk("t6_queued", 32'(a_cnt), 32'd2);
    @(negedge clk);
    repeat (45) @(negedge clk);
    chk("t6_bit3_low", 32'(a_tx), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_tx", 32'(a_tx), 32'd1);
    chk("t6_rst_count", 32'(a_cnt), 32'd0);
    chk("t6_rst_active", 32'(a_act), 32'd0);
    a_done_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    lowc = 0;
    repeat (150) begin
      @(negedge clk);
      if (!a_tx || a_act) lowc++;
    end
    chk("t6_line_idle", 32'(lowc), 32'd0);
    chk("t6_no_done", 32'(a_done_cnt), 32'd0);
    push(1'b0, 8'h5A, 1'b0);
    measure(1'b0, len, lv, dn);
    chk("t6_after_len", 32'(len), 32'd100);
    chk("t6_after_bits", 32'(lv), 32'h2B4);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised successor to the single-word UART transmitter. It accepts words through a valid/ready stream into an internal FIFO and serialises them LSB-first onto `tx_serial`. Data width, FIFO depth, clock and baud rate are compile-time parameters; parity mode and stop-bit count are runtime-selectable. It sits between any on-chip producer and the UART pin, and removes the need for the producer to wait on `tx_done` per byte.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division); must be >= 2.
- `DATA_BITS`, 8: payload width, legal range 5..9.
- `DEPTH`, 16: FIFO depth in words; power of two, >= 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  producer has a word on `s_data`.
- `s_ready`  out  1  FIFO can accept a word (`fifo_count != DEPTH`).
- `s_data`  in  DATA_BITS  word to transmit.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `two_stop`  in  1  0 = one stop bit, 1 = two stop bits.
- `tx_serial`  out  1  UART line; idle high.
- `tx_active`  out  1  high from the first start-bit cycle to the last stop-bit cycle of every frame.
- `tx_done`  out  1  one-cycle pulse after each frame completes.
- `fifo_count`  out  $clog2(DEPTH+1)  words currently buffered.

## Operation
- A push occurs on a rising edge where `s_valid && s_ready` is true. Words are emitted in push order.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: when the FIFO is non-empty. That edge pops the head word into the shift register. It also latches `parity_mode` and `two_stop` for the whole frame, so changes mid-frame are ignored.
  - START: drives 0 for one bit period.
  - DATA: drives `DATA_BITS` bits, LSB first, one bit period each.
  - PARITY: entered only if the latched mode is even or odd; drives one bit period.
    - Even mode drives the XOR of the data bits.
    - Odd mode drives its inverse.
  - STOP: drives 1 for one bit period, or two periods if `two_stop` was latched.
  - STOP → IDLE: on the last cycle of the stop period. `tx_done` pulses for 1 cycle in the IDLE cycle entered.
- Frame length is `(1 + DATA_BITS + P + S) * CLKS_PER_BIT` cycles, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- The baud counter counts 0..CLKS_PER_BIT-1 and restarts at every bit boundary.
- Push and pop on the same edge leave `fifo_count` unchanged. There is no bypass: a word pushed into an empty FIFO is popped on the following edge.
- When the FIFO is full, `s_ready` is 0 and the push is refused. A pop on that edge is reflected in `s_ready` the next cycle.

## Timing
- Reset values, applied immediately and asynchronously:
  - `tx_serial`=1, `tx_active`=0, `tx_done`=0, `s_ready`=1, `fifo_count`=0.
  - FSM in IDLE, FIFO empty, baud and bit counters 0.
- Reset mid-frame: the line returns high at once and the partial frame is abandoned. No `tx_done` is produced, and all buffered words are discarded.
- Push-to-line latency on an idle, empty block:
  - A push at edge E makes `fifo_count`=1 after E.
  - The pop happens at E+1, and `tx_serial` falls and `tx_active` rises after E+1.
- Back-to-back frames: the single IDLE cycle carrying `tx_done` separates them, giving exactly 1 clock of extra idle-high between the last stop bit and the next start bit.
- `tx_active` is 0 in IDLE, including the `tx_done` cycle.
- All outputs are registered.

## Structure
- The shared package `uart_pkg` holds:
  - Parity-mode constants `PARITY_NONE`=2'b00, `PARITY_EVEN`=2'b01, `PARITY_ODD`=2'b10.
  - The FSM state enumeration.
  - A function computing `CLKS_PER_BIT`.
  - These are reused by the future receiver.
- Sub-module `uart_sync_fifo` implements the FIFO:
  - Parameters: WIDTH, DEPTH.
  - Interface: push/pop, full/empty, count.
  - Pointers are `$clog2(DEPTH)` bits plus a wrap bit.
  - It has its own asynchronous reset.
- The top level contains the FSM, baud counter, bit counter, shift register and parity accumulator.

## Test plan
Use `CLK_FREQ`=1000000 and `BAUD_RATE`=100000, giving `CLKS_PER_BIT`=10.

1. `DATA_BITS`=8, no parity, one stop bit, push 0x41 → line carries 0,1,0,0,0,0,0,1,0,1 for 10 cycles each. `tx_active` is high for exactly 100 cycles. A single `tx_done` pulse follows.
2. Push 0x41 with even parity → parity bit 0 and frame length 110 cycles. Repeat with odd parity → parity bit 1. Repeat with mode 11 → no parity bit, 100 cycles.
3. `two_stop`=1, no parity, push 0xFF → stop level held for 20 cycles and frame length 110 cycles. Toggling `two_stop` and `parity_mode` mid-frame does not alter the frame.
4. `DEPTH`=4, hold `s_valid` high with 0x01..0x06:
   - `s_ready` falls after 5 accepts, once `fifo_count`=4.
   - Every word pushed while `s_ready`=1 is emitted in order.
   - Frames are separated by exactly 1 idle cycle.
   - 6 `tx_done` pulses occur.
5. `DATA_BITS`=5, push 5'h15 → line carries 0,1,0,1,0,1,1 and frame length 70 cycles.
6. Assert `rst` during data bit 3 with 2 words queued:
   - `tx_serial`=1 and `fifo_count`=0 in the same cycle.
   - No `tx_done` pulse.
   - After release, the line stays idle until a new push.
